// File: rtl/regfile_scoreboard_if.sv
// Register file bus: two read ports, two write ports, an alloc port and the busy count.
// The register file uses the slave modport and the issue/writeback side uses the master modport.
//   rn_*/rm_*      read ports A/B: address in; data and ready out
//   wr0_*/wr1_*    write ports (ALU writeback / load return)
//   alloc_*        marks a destination register pending
//   busy_count     number of pending registers (registered)
interface regfile_scoreboard_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 5
);
  logic [ADDR_W-1:0] rn_addr;
  logic [ADDR_W-1:0] rm_addr;
  logic [DATA_W-1:0] rn_data;
  logic [DATA_W-1:0] rm_data;
  logic              rn_ready;
  logic              rm_ready;
  logic              wr0_en;
  logic [ADDR_W-1:0] wr0_addr;
  logic [DATA_W-1:0] wr0_data;
  logic              wr1_en;
  logic [ADDR_W-1:0] wr1_addr;
  logic [DATA_W-1:0] wr1_data;
  logic              alloc_en;
  logic [ADDR_W-1:0] alloc_addr;
  logic [ADDR_W:0]   busy_count;

  modport master (
    output rn_addr, rm_addr, wr0_en, wr0_addr, wr0_data,
    output wr1_en, wr1_addr, wr1_data, alloc_en, alloc_addr,
    input  rn_data, rm_data, rn_ready, rm_ready, busy_count
  );

  modport slave (
    input  rn_addr, rm_addr, wr0_en, wr0_addr, wr0_data,
    input  wr1_en, wr1_addr, wr1_data, alloc_en, alloc_addr,
    output rn_data, rm_data, rn_ready, rm_ready, busy_count
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register file with a per-register pending scoreboard for the pipelined datapath.
// Ports:
//   clk    clock, all state updates on posedge
//   reset  synchronous active-high reset; clears data, pending bits and busy_count
//   bus    regfile_scoreboard_if slave: 2 combinational read ports with ready,
//          2 write ports (wr1 wins on collision), alloc port, registered busy_count
// ZERO_REG always reads 0/ready and ignores writes and allocs. With BYPASS=1 a read of a
// register being written this cycle returns the write data (not while reset is high).
module regfile_scoreboard #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 31,
  parameter bit          BYPASS   = 1'b1
) (
  input logic                 clk,
  input logic                 reset,
  regfile_scoreboard_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  pending_q, pending_d;
  logic [CNT_W-1:0]  busy_q, busy_d;

  logic wr0_v, wr1_v, alloc_v;
  logic inc, dec0, dec1;

  assign wr0_v   = bus.wr0_en   && (bus.wr0_addr   != ZERO_ADDR);
  assign wr1_v   = bus.wr1_en   && (bus.wr1_addr   != ZERO_ADDR);
  assign alloc_v = bus.alloc_en && (bus.alloc_addr != ZERO_ADDR);

  // Writes clear pending, then alloc sets it: the alloc belongs to the newer instruction.
  always_comb begin
    pending_d = pending_q;
    if (wr0_v)   pending_d[bus.wr0_addr]   = 1'b0;
    if (wr1_v)   pending_d[bus.wr1_addr]   = 1'b0;
    if (alloc_v) pending_d[bus.alloc_addr] = 1'b1;
  end

  // Incremental count: each bit that really flips is counted once, so a double write to one
  // address, or a write overridden by an alloc to the same address, is not double-counted.
  always_comb begin
    inc  = alloc_v && !pending_q[bus.alloc_addr];
    dec0 = wr0_v && pending_q[bus.wr0_addr] &&
           !(alloc_v && (bus.alloc_addr == bus.wr0_addr));
    dec1 = wr1_v && pending_q[bus.wr1_addr] &&
           !(alloc_v && (bus.alloc_addr == bus.wr1_addr)) &&
           !(wr0_v && (bus.wr0_addr == bus.wr1_addr));
    busy_d = busy_q + CNT_W'(inc) - CNT_W'(dec0) - CNT_W'(dec1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      pending_q <= '0;
      busy_q    <= '0;
    end else begin
      if (wr0_v) mem_q[bus.wr0_addr] <= bus.wr0_data;
      // Later assignment gives wr1 priority on an address collision.
      if (wr1_v) mem_q[bus.wr1_addr] <= bus.wr1_data;
      pending_q <= pending_d;
      busy_q    <= busy_d;
    end
  end

  logic [ADDR_W-1:0] rd_addr  [2];
  logic [DATA_W-1:0] rd_data  [2];
  logic              rd_ready [2];

  assign rd_addr[0] = bus.rn_addr;
  assign rd_addr[1] = bus.rm_addr;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p]  = mem_q[rd_addr[p]];
      rd_ready[p] = !pending_q[rd_addr[p]];
      if (BYPASS && !reset) begin
        if (wr0_v && (bus.wr0_addr == rd_addr[p])) begin
          rd_data[p]  = bus.wr0_data;
          rd_ready[p] = 1'b1;
        end
        if (wr1_v && (bus.wr1_addr == rd_addr[p])) begin
          rd_data[p]  = bus.wr1_data;
          rd_ready[p] = 1'b1;
        end
      end
      if (rd_addr[p] == ZERO_ADDR) begin
        rd_data[p]  = '0;
        rd_ready[p] = 1'b1;
      end
    end
  end

  assign bus.rn_data    = rd_data[0];
  assign bus.rm_data    = rd_data[1];
  assign bus.rn_ready   = rd_ready[0];
  assign bus.rm_ready   = rd_ready[1];
  assign bus.busy_count = busy_q;

endmodule
